fsqrt_sched: RTL and testbench

FSQRT_SCHED -- requirements
Module: fsqrt_sched

---
 rtl/fsqrt_sched_if.sv | 27 ++
 rtl/fsqrt_sched.sv | 120 ++++++++++++
 tb/tb_fsqrt_sched.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsqrt_sched_if.sv
// Handshake bundle for the fsqrt scheduler: issue side, fsqrt pipeline side,
// result side and the busy flag.
interface fsqrt_sched_if #(
  parameter int unsigned TAGW = 5
);
  logic            in_valid;
  logic [31:0]     in_op;
  logic [TAGW-1:0] in_tag;
  logic            in_ready;
  logic [31:0]     sq_op;
  logic [31:0]     sq_result;
  logic            out_valid;
  logic [31:0]     out_result;
  logic [TAGW-1:0] out_tag;
  logic            out_ready;
  logic            busy;

  modport master (
    output in_valid, in_op, in_tag, sq_result, out_ready,
    input  in_ready, sq_op, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_tag, sq_result, out_ready,
    output in_ready, sq_op, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/fsqrt_sched.sv
// Credit-based scheduler around a fixed-latency, non-stalling fsqrt pipeline:
// tracks tags/special cases alongside it and collects results in an in-order FIFO.
module fsqrt_sched #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAGW    = 5
) (
  input logic         clk,
  input logic         reset,
  fsqrt_sched_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {
    K_NORM    = 2'd0,
    K_NEG     = 2'd1,
    K_NEGZERO = 2'd2
  } kind_t;

  logic [LATENCY-1:0] vld;
  logic [TAGW-1:0]    stg_tag  [LATENCY];
  kind_t              stg_kind [LATENCY];

  logic [31:0]        mem_res [DEPTH];
  logic [TAGW-1:0]    mem_tag [DEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW:0]        cnt;

  logic               issue;
  logic               push;
  logic               pop;
  kind_t              in_kind;
  logic [31:0]        push_res;
  logic [CW-1:0]      credit;

  assign issue = bus.in_valid & bus.in_ready;
  assign push  = vld[LATENCY-1];
  assign pop   = bus.out_valid & bus.out_ready;

  assign bus.sq_op = {1'b0, bus.in_op[30:0]};

  always_comb begin
    in_kind = K_NORM;
    if (bus.in_op == 32'h8000_0000)
      in_kind = K_NEGZERO;
    else if (bus.in_op[31])
      in_kind = K_NEG;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stg_tag[i]  <= '0;
        stg_kind[i] <= K_NORM;
      end
    end else begin
      vld[0]      <= issue;
      stg_tag[0]  <= bus.in_tag;
      stg_kind[0] <= in_kind;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i]      <= vld[i-1];
        stg_tag[i]  <= stg_tag[i-1];
        stg_kind[i] <= stg_kind[i-1];
      end
    end
  end

  always_comb begin
    push_res = bus.sq_result;
    case (stg_kind[LATENCY-1])
      K_NEG:     push_res = 32'h7FC0_0000;
      K_NEGZERO: push_res = 32'h8000_0000;
      default:   push_res = bus.sq_result;
    endcase
  end

  // Every in-flight op already owns a FIFO slot, so the FIFO cannot overflow.
  always_comb begin
    credit = CW'(cnt);
    for (int unsigned i = 0; i < LATENCY; i++)
      credit = credit + CW'(vld[i]);
  end

  assign bus.in_ready = (credit < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wptr] <= push_res;
      mem_tag[wptr] <= stg_tag[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.out_valid  = (cnt != '0);
  assign bus.out_result = bus.out_valid ? mem_res[rptr] : '0;
  assign bus.out_tag    = bus.out_valid ? mem_tag[rptr] : '0;
  assign bus.busy       = (|vld) | bus.out_valid;

endmodule

// File: tb/tb_fsqrt_sched.sv
// Directed bench for fsqrt_sched with a fixed-latency fsqrt stand-in model.
module tb_fsqrt_sched;

  localparam int unsigned L  = 3;
  // DEPTH above LATENCY+1 so the credit loop can sustain one issue per cycle.
  localparam int unsigned D  = 8;
  localparam int unsigned TW = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fsqrt_sched_if #(.TAGW(TW)) bus ();

  fsqrt_sched #(
    .LATENCY(L),
    .DEPTH  (D),
    .TAGW   (TW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in fsqrt: classic exponent-halving approximation, 4.0 -> 2.0.
  function automatic logic [31:0] fsq(input logic [31:0] x);
    return {1'b0, x[30:0] >> 1} + 32'h1FC0_0000;
  endfunction

  function automatic logic [31:0] exp_res(input logic [31:0] op);
    if (op == 32'h8000_0000) return 32'h8000_0000;
    if (op[31])              return 32'h7FC0_0000;
    return fsq(op);
  endfunction

  logic [31:0] fpipe [L];
  always @(posedge clk) begin
    fpipe[0] <= fsq(bus.sq_op);
    for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
  end
  assign bus.sq_result = fpipe[L-1];

  always @(posedge clk) begin
    if (reset && u_dut.push && (u_dut.cnt == D)) begin
      errors++;
      $display("FAIL fifo_overflow: push with occupancy %0d, required < %0d", u_dut.cnt, D);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_op = 32'hC080_0000;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result: got %h want 0", bus.out_result); end
    checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag); end
    checks++; if (bus.sq_op !== 32'h4080_0000) begin errors++; $display("FAIL sq_op_mask: got %h want 40800000", bus.sq_op); end
    step();
    reset = 1'b1;
    bus.in_op = '0;
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_op = 32'h4080_0000; bus.in_tag = 5'd3; bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after_reset: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < L; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL single_latency k=%0d: out_valid %b busy %b want 0/1", k, bus.out_valid, bus.busy);
      end
      step();
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h4000_0000) begin errors++; $display("FAIL single_result: got %h want 40000000", bus.out_result); end
    checks++; if (bus.out_tag !== 5'd3) begin errors++; $display("FAIL single_tag: got %0d want 3", bus.out_tag); end
    step(); step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h4000_0000 || bus.out_tag !== 5'd3) begin
      errors++; $display("FAIL single_hold: got %b/%h/%0d want 1/40000000/3", bus.out_valid, bus.out_result, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_pop: out_valid %b busy %b want 0/0", bus.out_valid, bus.busy);
    end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pop_when_empty: out_valid %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_special();
    logic [31:0] ops  [3];
    logic [31:0] want [3];
    int n;
    ops[0] = 32'hC080_0000; want[0] = 32'h7FC0_0000;
    ops[1] = 32'h8000_0000; want[1] = 32'h8000_0000;
    ops[2] = 32'h0000_0000; want[2] = 32'h1FC0_0000;
    n = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      if (c < 3) begin
        bus.in_valid = 1'b1; bus.in_op = ops[c]; bus.in_tag = TW'(c + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.out_result !== want[n] || bus.out_tag !== TW'(n + 1)) begin
          errors++; $display("FAIL special_%0d: got %h/%0d want %h/%0d", n, bus.out_result, bus.out_tag, want[n], n + 1);
        end
        n++;
      end
      step();
    end
    checks++; if (n != 3) begin errors++; $display("FAIL special_count: got %0d want 3", n); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int issued;
    int n;
    issued = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.in_tag = TW'(issued);
      bus.in_op  = 32'h3F80_0000 + (32'(issued) << 16);
      if (bus.in_ready) issued++;
      step();
    end
    checks++; if (issued != D) begin errors++; $display("FAIL bp_issue_count: got %0d want %0d", issued, D); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < D; c++) begin
      if (bus.out_valid) begin
        checks++;
        if (bus.out_tag !== TW'(n) || bus.out_result !== fsq(32'h3F80_0000 + (32'(n) << 16))) begin
          errors++; $display("FAIL bp_drain_%0d: got %h/%0d want %h/%0d", n, bus.out_result, bus.out_tag,
                             fsq(32'h3F80_0000 + (32'(n) << 16)), n);
        end
        n++;
        step();
        if (n == 1) begin
          checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.in_ready); end
        end
      end else begin
        step();
      end
    end
    checks++; if (n != D) begin errors++; $display("FAIL bp_drain_count: got %0d want %0d", n, D); end
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [TW+31:0] q[$];
    logic [TW+31:0] head;
    logic [31:0]    r;
    int issued, got, stalls, ncyc;
    issued = 0; got = 0; stalls = 0; ncyc = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 1200 && got < 1000; c++) begin
      if (issued < 1000) begin
        r = $urandom; r[31] = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = r; bus.in_tag = TW'(issued);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({bus.in_tag, exp_res(bus.in_op)});
        issued++;
      end
      if (bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_unexpected: got %h/%0d with nothing outstanding", bus.out_result, bus.out_tag);
        end else begin
          head = q.pop_front();
          if ({bus.out_tag, bus.out_result} !== head) begin
            errors++; $display("FAIL stream_%0d: got %h/%0d want %h/%0d", got, bus.out_result, bus.out_tag,
                               head[31:0], head[TW+31:32]);
          end
        end
        got++;
        ncyc = c + 1;
      end
      step();
    end
    checks++; if (got != 1000) begin errors++; $display("FAIL stream_count: got %0d want 1000", got); end
    checks++; if (stalls != 0) begin errors++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
    checks++; if (ncyc > 1000 + L + 2) begin errors++; $display("FAIL stream_rate: got %0d cycles want <= %0d", ncyc, 1000 + L + 2); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = 32'h4080_0000; bus.in_tag = 5'd1;
    step();
    bus.in_op = 32'h4100_0000; bus.in_tag = 5'd2;
    step();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midflight_busy_in_reset: got %b want 0", bus.busy); end
    step();
    reset = 1'b1;
    for (int k = 0; k < L + 2; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL midflight_k%0d: out_valid %b busy %b want 0/0", k, bus.out_valid, bus.busy);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    int n;
    pulse_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c <= 7 + L; c++) begin
      bus.in_valid  = (c < D);
      bus.in_tag    = TW'(c);
      bus.in_op     = 32'h4000_0000 + (32'(c) << 20);
      bus.out_ready = (c == 7 + L);
      if (c < D) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_issue_%0d: in_ready %b want 1", c, bus.in_ready); end
      end
      if (c == 7 + L) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL wrap_full_credit: in_ready %b want 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== TW'(0) || bus.out_result !== fsq(32'h4000_0000)) begin
          errors++; $display("FAIL wrap_head: got %b/%h/%0d want 1/%h/0", bus.out_valid, bus.out_result, bus.out_tag,
                             fsq(32'h4000_0000));
        end
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_occupancy: in_ready %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && bus.out_valid; c++) begin
      checks++;
      if (bus.out_tag !== TW'(n + 1) || bus.out_result !== fsq(32'h4000_0000 + (32'(n + 1) << 20))) begin
        errors++; $display("FAIL wrap_order_%0d: got %h/%0d want %h/%0d", n, bus.out_result, bus.out_tag,
                           fsq(32'h4000_0000 + (32'(n + 1) << 20)), n + 1);
      end
      n++;
      step();
    end
    checks++; if (n != D - 1) begin errors++; $display("FAIL wrap_count: got %0d want %0d", n, D - 1); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_inputs();
    step(); step();
    test_reset();
    test_single();
    test_special();
    test_backpressure();
    test_stream();
    test_reset_midflight();
    test_wrap();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
